// File: rtl/mem_pkg.sv
// Shared types and default widths for the data memory controller slice.
package mem_pkg;

   // Controller state: CLEAR while the zeroing sweep runs, READY otherwise
   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 8;

endpackage

// File: rtl/mem_array.sv
// Plain storage array: one synchronous write port, one registered read port.
// Contents have no reset; the controller's clear engine zeroes them instead.
module mem_array #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 2**ADDR_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Commit writes and register the read word on every rising edge
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/data_memory_ctrl.sv
// Data memory controller: valid/ready request port, one-cycle read responses,
// out-of-range detection and a hardware sweep that zeroes every word.
module data_memory_ctrl
   import mem_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = 2**ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic              clear_req,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              init_busy
);

   // One extra pointer bit keeps the terminal compare valid when DEPTH = 2**ADDR_W
   localparam logic [ADDR_W:0] DEPTH_P  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);

   state_t            state_q;
   state_t            state_d;
   logic [ADDR_W:0]   ptr_q;
   logic              addr_ok;
   logic              accept;
   logic              rd_accept;
   logic              rsp_valid_q;
   logic              rsp_err_q;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic [ADDR_W-1:0] mem_raddr;
   logic [DATA_W-1:0] mem_rdata;

   assign addr_ok   = {1'b0, req_addr} < DEPTH_P;
   assign accept    = req_valid && req_ready;
   assign rd_accept = accept && !req_write;
   assign mem_raddr = addr_ok ? req_addr : '0;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CLEAR;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: sweep ends after the last word; clear_req restarts it from READY only
   always_comb begin
      state_d = state_q;
      case (state_q)
         CLEAR:   if (ptr_q == LAST_PTR) state_d = READY;
         READY:   if (clear_req)         state_d = CLEAR;
         default: state_d = CLEAR;
      endcase
   end

   // Handshake outputs: clear_req blocks acceptance so it wins over a same-cycle request
   always_comb begin
      req_ready = 1'b0;
      init_busy = 1'b1;
      if (state_q == READY) begin
         req_ready = !clear_req;
         init_busy = 1'b0;
      end
   end

   // Clear pointer advances during the sweep and sits at zero while READY
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (state_q == CLEAR) begin
         ptr_q <= ptr_q + 1'b1;
      end else begin
         ptr_q <= '0;
      end
   end

   // Write port mux: clear engine owns the array during the sweep, requests otherwise
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = req_addr;
      mem_wdata = req_wdata;
      if (state_q == CLEAR) begin
         mem_we    = 1'b1;
         mem_waddr = ptr_q[ADDR_W-1:0];
         mem_wdata = '0;
      end else begin
         mem_we = accept && req_write && addr_ok;
      end
   end

   // Response flags for reads accepted at the previous edge; reset discards them
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         rsp_valid_q <= rd_accept;
         rsp_err_q   <= rd_accept && !addr_ok;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = (rsp_valid_q && !rsp_err_q) ? mem_rdata : '0;

   mem_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_mem_array (
      .clk   (clk),
      .we    (mem_we),
      .waddr (mem_waddr),
      .wdata (mem_wdata),
      .raddr (mem_raddr),
      .rdata (mem_rdata)
   );

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl with DATA_W=8, ADDR_W=4, DEPTH=12.
module tb_data_memory_ctrl;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 12;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              clear_req;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              init_busy;

   int assertCount = 0;
   int failCount   = 0;

   // Behavioural model: remaining sweep cycles, memory image, pending response
   int          clearLeft;
   logic [7:0]  modelMem [DEPTH];
   logic        expValid;
   logic        expErr;
   logic [7:0]  expData;

   // Every response seen by the checker, as {err, data}
   logic [8:0]  rspLog [$];

   always #5 clk = ~clk;

   data_memory_ctrl #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .clear_req (clear_req),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .init_busy (init_busy)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one request cycle: inputs change 1 time unit after a rising edge
   task automatic applyStimulus(input logic v, input logic w, input logic [3:0] a,
                                input logic [7:0] d, input logic c);
      req_valid = v;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      clear_req = c;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      clear_req = 1'b0;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 1'b0, 4'd0, 8'd0, 1'b0);
   endtask

   // Count busy cycles until req_ready is allowed again, bounded
   task automatic waitReady(input int expCycles, input string name);
      int n = 0;
      while (n < 40) begin
         @(negedge clk);
         if (!init_busy) break;
         n++;
      end
      checkOutput(name, n, expCycles);
      @(posedge clk);
      #1;
   endtask

   // Model update: clear wins, then one request per cycle when not sweeping
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clearLeft = DEPTH;
         expValid  = 1'b0;
         expErr    = 1'b0;
         expData   = 8'h00;
         for (int i = 0; i < DEPTH; i++) modelMem[i] = 8'h00;
      end else begin
         expValid = 1'b0;
         expErr   = 1'b0;
         expData  = 8'h00;
         if (clearLeft > 0) begin
            clearLeft = clearLeft - 1;
         end else if (clear_req) begin
            clearLeft = DEPTH;
            for (int i = 0; i < DEPTH; i++) modelMem[i] = 8'h00;
         end else if (req_valid) begin
            if (req_write) begin
               if (int'(req_addr) < DEPTH) modelMem[req_addr] = req_wdata;
            end else begin
               expValid = 1'b1;
               if (int'(req_addr) < DEPTH) begin
                  expData = modelMem[req_addr];
               end else begin
                  expErr = 1'b1;
               end
            end
         end
      end
   end

   // Compare every output against the model once per cycle, mid-cycle
   always @(negedge clk) begin
      checkOutput("init_busy", init_busy, (clearLeft > 0) ? 1 : 0);
      checkOutput("req_ready", req_ready, (rst_n && clearLeft == 0 && !clear_req) ? 1 : 0);
      checkOutput("rsp_valid", rsp_valid, expValid);
      checkOutput("rsp_err",   rsp_err,   expErr);
      checkOutput("rsp_rdata", rsp_rdata, expData);
      if (rsp_valid) rspLog.push_back({rsp_err, rsp_rdata});
   end

   initial begin
      logic [7:0] pattern;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      clear_req = 1'b0;

      // Reset values while rst_n is held low
      #3;
      checkOutput("reset_req_ready", req_ready, 0);
      checkOutput("reset_init_busy", init_busy, 1);
      checkOutput("reset_rsp_valid", rsp_valid, 0);
      checkOutput("reset_rsp_rdata", rsp_rdata, 0);
      checkOutput("reset_rsp_err",   rsp_err,   0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      waitReady(12, "init_cycles_after_reset");

      // All words read back zero after the sweep
      rspLog.delete();
      for (int a = 0; a < DEPTH; a++) applyStimulus(1'b1, 1'b0, 4'(a), 8'h00, 1'b0);
      idle();
      checkOutput("zero_read_count", rspLog.size(), 12);
      for (int i = 0; i < rspLog.size(); i++) checkOutput("zero_read_data", rspLog[i], 9'h000);

      // Write then immediately read back the same address
      rspLog.delete();
      applyStimulus(1'b1, 1'b1, 4'd3, 8'hA5, 1'b0);
      applyStimulus(1'b1, 1'b0, 4'd3, 8'h00, 1'b0);
      idle();
      checkOutput("wr_rd_count", rspLog.size(), 1);
      if (rspLog.size() > 0) checkOutput("wr_rd_data", rspLog[0], 9'h0A5);

      // Out-of-range write is dropped and out-of-range read flags an error
      rspLog.delete();
      applyStimulus(1'b1, 1'b1, 4'd13, 8'h77, 1'b0);
      applyStimulus(1'b1, 1'b0, 4'd13, 8'h00, 1'b0);
      for (int a = 0; a < DEPTH; a++) applyStimulus(1'b1, 1'b0, 4'(a), 8'h00, 1'b0);
      idle();
      checkOutput("oor_count", rspLog.size(), 13);
      if (rspLog.size() == 13) begin
         checkOutput("oor_err_rsp", rspLog[0], 9'h100);
         for (int i = 1; i < 13; i++)
            checkOutput("no_alias", rspLog[i], (i - 1 == 3) ? 9'h0A5 : 9'h000);
      end

      // Read before clear keeps old data; clear beats a same-cycle request
      rspLog.delete();
      applyStimulus(1'b1, 1'b1, 4'd5, 8'h3C, 1'b0);
      applyStimulus(1'b1, 1'b0, 4'd5, 8'h00, 1'b0);
      applyStimulus(1'b1, 1'b0, 4'd5, 8'h00, 1'b1);
      waitReady(12, "init_cycles_after_clear");
      applyStimulus(1'b1, 1'b0, 4'd5, 8'h00, 1'b0);
      idle();
      checkOutput("clear_rsp_count", rspLog.size(), 2);
      if (rspLog.size() == 2) begin
         checkOutput("pre_clear_data", rspLog[0], 9'h03C);
         checkOutput("post_clear_data", rspLog[1], 9'h000);
      end

      // Reset asserted in cycle 6 of a sweep returns outputs to reset values at once
      applyStimulus(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
      repeat (5) idle();
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_req_ready", req_ready, 0);
      checkOutput("midreset_init_busy", init_busy, 1);
      checkOutput("midreset_rsp_valid", rsp_valid, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      waitReady(12, "init_cycles_after_midreset");

      // Back-to-back reads after writing addr * 0x11
      for (int a = 0; a < DEPTH; a++) begin
         pattern = 8'(a * 8'h11);
         applyStimulus(1'b1, 1'b1, 4'(a), pattern, 1'b0);
      end
      rspLog.delete();
      for (int a = 0; a < DEPTH; a++) applyStimulus(1'b1, 1'b0, 4'(a), 8'h00, 1'b0);
      idle();
      checkOutput("b2b_count", rspLog.size(), 12);
      if (rspLog.size() == 12) begin
         checkOutput("b2b_first", rspLog[0], 9'h000);
         checkOutput("b2b_mid",   rspLog[6], 9'h066);
         checkOutput("b2b_last",  rspLog[11], 9'h0BB);
         for (int i = 0; i < 12; i++) checkOutput("b2b_data", rspLog[i], 9'(i * 8'h11));
      end

      idle();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/data_memory_ctrl.md
# data_memory_ctrl

Parametrised single-port data memory with a valid/ready request interface, registered read responses, out-of-range detection, and a hardware clear engine. Next-generation replacement for the fixed 8-bit/16-entry data store. Sits between the processor datapath (load/store unit) and the storage array. Guarantees all-zero contents after reset without simulation-only initialisation.

## Interface
Parameters:
- DATA_W, 8, data word width in bits
- ADDR_W, 8, address width in bits
- DEPTH, 2**ADDR_W, number of implemented words; 1 ≤ DEPTH ≤ 2**ADDR_W

Ports:
- clk  in  1  rising-edge clock, sole clock of the block
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready at a rising edge
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- clear_req  in  1  single-cycle pulse; starts a full zeroing sweep
- rsp_valid  out  1  read response valid, one cycle per accepted read
- rsp_rdata  out  DATA_W  read data; forced to 0 when rsp_valid = 0
- rsp_err  out  1  qualifies rsp_valid; 1 = address ≥ DEPTH
- init_busy  out  1  clear sweep in progress

## Operation
- States: CLEAR, READY.
- Reset: state = CLEAR, clear pointer = 0. Outputs: req_ready 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, init_busy 1.
- CLEAR: writes 0 to word[ptr] each cycle, ptr += 1. After word DEPTH-1 is written, go to READY. init_busy = 1 and req_ready = 0 throughout.
- READY: req_ready = !clear_req (combinational). init_busy = 0.
- clear_req in READY: takes priority over a same-cycle request. The request is not accepted. Next state is CLEAR with ptr = 0.
- clear_req in CLEAR: ignored; the sweep does not restart.
- Accepted write, addr < DEPTH: word[addr] ← req_wdata at that edge. No response is produced.
- Accepted write, addr ≥ DEPTH: dropped. No response and no error is signalled.
- Accepted read, addr < DEPTH: the next cycle has rsp_valid = 1, rsp_err = 0, rsp_rdata = word[addr].
- Accepted read, addr ≥ DEPTH: the next cycle has rsp_valid = 1, rsp_err = 1, rsp_rdata = 0.
- No back-pressure on responses. The consumer must always accept rsp_valid.
- Reset asserted mid-sweep or mid-read: any pending response is discarded (rsp_valid 0). After rst_n releases, the sweep restarts from 0.

## Timing
- Read latency: exactly 1 cycle from the accepting edge to rsp_valid.
- Throughput: one request per cycle, reads and writes freely interleaved.
- Write then read of the same address on consecutive cycles: the read returns the new data. Write-first is inherent because the write commits at the earlier edge.
- Clear duration: exactly DEPTH cycles after reset release or after a clear_req edge. req_ready rises on the cycle after the last zero write.
- Read accepted on the cycle before clear_req: the response is still delivered, during the first CLEAR cycle, with pre-clear data.
- Clear pointer width: ADDR_W + 1 bits, so the terminal compare works when DEPTH = 2**ADDR_W.

## Structure
- Shared package mem_pkg holds:
  - state typedef (CLEAR, READY)
  - default width constants (DATA_W_DEF = 8, ADDR_W_DEF = 8)
- Sub-module mem_array (DATA_W, DEPTH):
  - one synchronous write port
  - one synchronous read port with registered output
  - no reset on storage contents
- The controller muxes the write port between the clear engine and the request path.
- The controller generates rsp_valid, rsp_err and rsp_rdata gating.

## Test plan
All scenarios use DATA_W=8, ADDR_W=4, DEPTH=12.
- Reset release: init_busy = 1 for exactly 12 cycles, then req_ready = 1. Reads of addresses 0..11 all return 0x00.
- Write 0xA5 to addr 3, then read addr 3 on the next cycle: rsp_valid one cycle after the read, rsp_rdata = 0xA5, rsp_err = 0.
- Read addr 13: rsp_valid = 1, rsp_err = 1, rsp_rdata = 0x00. A prior write of 0x77 to addr 13 must not alias onto any word 0..11.
- Write 0x3C to addr 5, then pulse clear_req with req_valid high in the same cycle: that request is not accepted. Afterwards init_busy = 1 for 12 cycles, and a read of addr 5 then returns 0x00.
- Pulse rst_n low during cycle 6 of a sweep: all outputs return to their reset values immediately. The full 12-cycle sweep restarts after release.
- Back-to-back reads of addr 0..11 after writing data = addr × 0x11: twelve consecutive rsp_valid pulses return 0x00, 0x11, … 0xBB in order.
